// File: rtl/branch_pc_unit_pkg.sv
// Shared encodings for the branch/PC stage and the decode stage.
package branch_pc_unit_pkg;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_BLT = 2'b10,
    BR_JMP = 2'b11
  } br_op_e;

  // Comparator ControlSignal select codes
  localparam logic CMP_EQ = 1'b0;
  localparam logic CMP_LT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_EVAL     = 2'b01,
    S_REDIRECT = 2'b10
  } state_e;

  // 16-bit modular add; the carry is dropped on purpose (PC and target wrap)
  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Upstream branch request / comparator / fetch-side signals of the PC stage.
interface branch_pc_if;
  import branch_pc_unit_pkg::*;

  logic        BranchValid;
  br_op_e      BranchOp;
  logic [15:0] BranchPC;
  logic [15:0] Offset;
  logic [15:0] CompR;
  logic        CompSel;
  logic [15:0] PC;
  logic        BranchReady;
  logic        Flush;
  logic        Taken;

  // Driver side: decode stage + comparator (or the bench)
  modport master (
    output BranchValid, BranchOp, BranchPC, Offset, CompR,
    input  CompSel, PC, BranchReady, Flush, Taken
  );

  // The branch/PC unit itself
  modport slave (
    input  BranchValid, BranchOp, BranchPC, Offset, CompR,
    output CompSel, PC, BranchReady, Flush, Taken
  );
endinterface

// File: rtl/branch_pc_unit_cond.sv
// Combinational branch condition: (op, CompR) -> taken, op -> comparator select.
module branch_cond
  import branch_pc_unit_pkg::*;
(
  input  br_op_e      op_i,
  input  logic [15:0] comp_r_i,
  output logic        taken_o,
  output logic        comp_sel_o
);

  // Decode op into a condition on the comparator result and a select code
  always_comb begin
    taken_o    = 1'b0;
    comp_sel_o = CMP_EQ;
    case (op_i)
      BR_BEQ: taken_o = (comp_r_i != 16'h0000);
      BR_BNE: taken_o = (comp_r_i == 16'h0000);
      BR_BLT: begin
        taken_o    = (comp_r_i != 16'h0000);
        comp_sel_o = CMP_LT;
      end
      BR_JMP: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register and branch resolution; predicts not-taken, redirects on taken.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  branch_pc_if.slave  bus
);

  localparam logic [15:0] STEP = 16'(PC_STEP);

  state_e      state_q;
  br_op_e      op_q;
  logic [15:0] pc_q, tgt_q;
  logic        taken_q, flush_q, ready_q;

  logic [15:0] pc_inc_d, tgt_d;
  logic        cond_taken, cond_sel;

  // Sequential next PC and the halfword-aligned branch target
  always_comb begin
    pc_inc_d = add16(pc_q, STEP);
    tgt_d    = add16(bus.BranchPC, bus.Offset);
    if (PC_STEP == 2) tgt_d[0] = 1'b0;
  end

  branch_cond u_cond (
    .op_i       (op_q),
    .comp_r_i   (bus.CompR),
    .taken_o    (cond_taken),
    .comp_sel_o (cond_sel)
  );

  // Branch FSM; all outputs except CompSel are registered here
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      op_q    <= BR_BEQ;
      tgt_q   <= 16'h0000;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (!Stall) begin
      case (state_q)
        S_IDLE: begin
          pc_q    <= pc_inc_d;
          flush_q <= 1'b0;
          if (bus.BranchValid && ready_q) begin
            op_q    <= bus.BranchOp;
            tgt_q   <= tgt_d;
            ready_q <= 1'b0;
            state_q <= S_EVAL;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_EVAL: begin
          if (cond_taken) begin
            pc_q    <= tgt_q;
            taken_q <= 1'b1;
            flush_q <= 1'b1;
            state_q <= S_REDIRECT;
          end else begin
            pc_q    <= pc_inc_d;
            taken_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_REDIRECT: begin
          pc_q    <= pc_inc_d;
          flush_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          flush_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // CompSel is Moore: only selects less-than while a BLT is being evaluated
  assign bus.CompSel     = (state_q == S_EVAL) ? cond_sel : CMP_EQ;
  assign bus.PC          = pc_q;
  assign bus.BranchReady = ready_q;
  assign bus.Flush       = flush_q;
  assign bus.Taken       = taken_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with a queue-based scoreboard.
module tb_branch_pc_unit;
  import branch_pc_unit_pkg::*;

  logic clk = 1'b0;
  logic rst, stall;
  always #5 clk = ~clk;

  branch_pc_if bus();

  branch_pc_unit #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .CLK   (clk),
    .Reset (rst),
    .Stall (stall),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic [15:0] pc;
    logic        rdy, fl, tk, cs;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Drive one cycle of inputs at negedge and queue the state expected after the next edge
  task automatic cyc(input string nm, input logic r, input logic s, input logic bv,
                     input br_op_e op, input logic [15:0] bpc, input logic [15:0] off,
                     input logic [15:0] cr, input logic [15:0] e_pc, input logic e_rdy,
                     input logic e_fl, input logic e_tk, input logic e_cs);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s;
    bus.BranchValid = bv; bus.BranchOp = op; bus.BranchPC = bpc;
    bus.Offset = off; bus.CompR = cr;
    e.nm = nm; e.pc = e_pc; e.rdy = e_rdy; e.fl = e_fl; e.tk = e_tk; e.cs = e_cs;
    q.push_back(e);
  endtask

  // Monitor: after each edge, pop the pending expectation and compare outputs
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if ({bus.PC, bus.BranchReady, bus.Flush, bus.Taken, bus.CompSel} !==
          {e.pc, e.rdy, e.fl, e.tk, e.cs}) begin
        n_fail++;
        $display("FAIL %s: got PC=%h rdy=%b fl=%b tk=%b cs=%b, want PC=%h rdy=%b fl=%b tk=%b cs=%b",
                 e.nm, bus.PC, bus.BranchReady, bus.Flush, bus.Taken, bus.CompSel,
                 e.pc, e.rdy, e.fl, e.tk, e.cs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0;
    bus.BranchValid = 1'b0; bus.BranchOp = BR_BEQ; bus.BranchPC = 16'h0; bus.Offset = 16'h0;
    bus.CompR = 16'h0;

    //   name          R  S  BV op      BPC      Off      CompR    PC       rdy fl tk cs
    cyc("reset",       1, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0000, 1, 0, 0, 0);
    cyc("free1",       0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0002, 1, 0, 0, 0);
    cyc("free2",       0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0004, 1, 0, 0, 0);
    cyc("free3",       0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0006, 1, 0, 0, 0);
    cyc("free4",       0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0008, 1, 0, 0, 0);
    // BEQ taken: target 0010+0020
    cyc("beq_acc",     0, 0, 1, BR_BEQ, 16'h0010, 16'h0020, 16'h0, 16'h000A, 0, 0, 0, 0);
    cyc("beq_res",     0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0001, 16'h0030, 0, 1, 1, 0);
    cyc("beq_redir",   0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0032, 1, 0, 1, 0);
    cyc("free5",       0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0034, 1, 0, 1, 0);
    // BNE with CompR nonzero: not taken
    cyc("bne_acc",     0, 0, 1, BR_BNE, 16'h0040, 16'h0100, 16'h0, 16'h0036, 0, 0, 1, 0);
    cyc("bne_res",     0, 0, 0, BR_BNE, 16'h0,   16'h0,   16'h0001, 16'h0038, 1, 0, 0, 0);
    cyc("free6",       0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h003A, 1, 0, 0, 0);
    // BLT with wrapping target FFF0+0020 = 0010; CompSel=1 while in EVAL
    cyc("blt_acc",     0, 0, 1, BR_BLT, 16'hFFF0, 16'h0020, 16'h0, 16'h003C, 0, 0, 0, 1);
    cyc("blt_res",     0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0001, 16'h0010, 0, 1, 1, 0);
    cyc("blt_redir",   0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0012, 1, 0, 1, 0);
    // JMP stalled 3 cycles in EVAL; BranchValid held high meanwhile must be ignored
    cyc("jmp_acc",     0, 0, 1, BR_JMP, 16'h0100, 16'h0050, 16'h0, 16'h0014, 0, 0, 1, 0);
    cyc("jmp_stall1",  0, 1, 1, BR_BNE, 16'h0,   16'h0,   16'h0,   16'h0014, 0, 0, 1, 0);
    cyc("jmp_stall2",  0, 1, 1, BR_BNE, 16'h0,   16'h0,   16'h0,   16'h0014, 0, 0, 1, 0);
    cyc("jmp_stall3",  0, 1, 0, BR_BNE, 16'h0,   16'h0,   16'h0,   16'h0014, 0, 0, 1, 0);
    cyc("jmp_res",     0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0000, 16'h0150, 0, 1, 1, 0);
    cyc("jmp_redir",   0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0152, 1, 0, 1, 0);
    // Reset while in REDIRECT with a request pending
    cyc("jmp2_acc",    0, 0, 1, BR_JMP, 16'h0200, 16'h0010, 16'h0, 16'h0154, 0, 0, 1, 0);
    cyc("jmp2_res",    0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0210, 0, 1, 1, 0);
    cyc("rst_redir",   1, 0, 1, BR_JMP, 16'h0300, 16'h0010, 16'h0, 16'h0000, 1, 0, 0, 0);
    cyc("post_rst",    0, 0, 0, BR_BEQ, 16'h0,   16'h0,   16'h0,   16'h0002, 1, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
